// File: rtl/sysbus_mmio_pkg.sv
// sysbus_mmio_pkg: register map, FSM states and byte-merge helper
// shared by the MMIO slave and its bench.
package sysbus_mmio_pkg;

  localparam logic [4:0] OFF_TXDATA   = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_MTIME_LO = 5'h08;
  localparam logic [4:0] OFF_MTIME_HI = 5'h0C;
  localparam logic [4:0] OFF_MTCMP_LO = 5'h10;
  localparam logic [4:0] OFF_MTCMP_HI = 5'h14;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  function automatic logic [31:0] f_wmerge(
    input logic [31:0] i_old,
    input logic [31:0] i_new,
    input logic [3:0]  i_strb
  );
    logic [31:0] v;
    v = i_old;
    for (int b = 0; b < 4; b++) begin
      if (i_strb[b]) v[8*b +: 8] = i_new[8*b +: 8];
    end
    return v;
  endfunction

endpackage

// File: rtl/sysbus_mmio_if.sv
// sysbus_mmio_if: request/response bus with valid/ready on both
// channels; master is the initiator, slave the MMIO block.
interface sysbus_mmio_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_write;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic        bus_resp_ready;
  logic [31:0] bus_resp_rdata;
  logic        bus_resp_error;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_write,
    output bus_req_wdata, bus_req_wstrb, bus_resp_ready,
    input  bus_req_ready, bus_resp_valid,
    input  bus_resp_rdata, bus_resp_error
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_write,
    input  bus_req_wdata, bus_req_wstrb, bus_resp_ready,
    output bus_req_ready, bus_resp_valid,
    output bus_resp_rdata, bus_resp_error
  );
endinterface

// File: rtl/sysbus_mmio_tx_fifo.sv
// tx_fifo: byte FIFO for the console; extra pointer bit tells full
// from empty, head reads 0 while empty.
module tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic        w_do_pop;
  logic        w_do_push;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head = o_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];

  // pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // storage needs no reset; head is masked while empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sysbus_mmio.sv
// sysbus_mmio: MMIO slave with console TX FIFO and 64-bit timer.
// One request in flight; response registered one cycle after accept.
module sysbus_mmio
  import sysbus_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  sysbus_mmio_if.slave bus,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready,
  output logic         timer_irq
);
  state_t      r_state;
  logic [31:0] r_rdata;
  logic        r_error;
  logic        r_ovf;
  logic [63:0] r_mtime;
  logic [63:0] r_mtcmp;
  logic        r_irq;

  logic [31:0] w_off;
  logic [4:0]  w_reg;
  logic        w_acc;
  logic        w_err;
  logic        w_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_clr;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_rd;
  logic [31:0] w_wd;
  logic [3:0]  w_st;

  assign w_wd  = bus.bus_req_wdata;
  assign w_st  = bus.bus_req_wstrb;
  assign w_acc = (r_state == S_IDLE) && bus.bus_req_valid;
  assign w_off = bus.bus_req_addr - BASE_ADDR;
  assign w_reg = w_off[4:0];
  assign w_err = (w_off[31:5] != '0) ||
                 (bus.bus_req_addr[1:0] != 2'b00) ||
                 (w_reg[4:3] == 2'b11);
  assign w_wr   = w_acc && !w_err && bus.bus_req_write;
  assign w_push = w_wr && (w_reg == OFF_TXDATA) && w_st[0];
  assign w_clr  = w_wr && (w_reg == OFF_STATUS) &&
                  w_st[0] && w_wd[2];
  assign w_pop    = tx_valid && tx_ready;
  assign tx_valid = !w_empty;

  assign bus.bus_req_ready  = (r_state == S_IDLE);
  assign bus.bus_resp_valid = (r_state == S_RESP);
  assign bus.bus_resp_rdata = r_rdata;
  assign bus.bus_resp_error = r_error;
  assign timer_irq = r_irq;

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_wd[7:0]),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (tx_data)
  );

  // read mux; TXDATA and holes read as zero
  always_comb begin
    w_rd = '0;
    unique case (w_reg)
      OFF_STATUS:   w_rd = {29'd0, r_ovf, w_full, w_empty};
      OFF_MTIME_LO: w_rd = r_mtime[31:0];
      OFF_MTIME_HI: w_rd = r_mtime[63:32];
      OFF_MTCMP_LO: w_rd = r_mtcmp[31:0];
      OFF_MTCMP_HI: w_rd = r_mtcmp[63:32];
      default:      w_rd = '0;
    endcase
  end

  // accept in IDLE, hold the latched response until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.bus_req_valid) begin
          r_rdata <= (bus.bus_req_write || w_err) ? '0 : w_rd;
          r_error <= w_err;
          r_state <= S_RESP;
        end
        S_RESP: if (bus.bus_resp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // sticky overflow on a dropped push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ovf <= 1'b0;
    else if (w_clr) r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
  end

  // free-running timer; a bus write replaces the increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mtime <= '0;
    else if (w_wr && w_reg == OFF_MTIME_LO)
      r_mtime <= {r_mtime[63:32],
                  f_wmerge(r_mtime[31:0], w_wd, w_st)};
    else if (w_wr && w_reg == OFF_MTIME_HI)
      r_mtime <= {f_wmerge(r_mtime[63:32], w_wd, w_st),
                  r_mtime[31:0]};
    else r_mtime <= r_mtime + 64'd1;
  end

  // compare register, byte writable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mtcmp <= '1;
    else if (w_wr && w_reg == OFF_MTCMP_LO)
      r_mtcmp[31:0] <= f_wmerge(r_mtcmp[31:0], w_wd, w_st);
    else if (w_wr && w_reg == OFF_MTCMP_HI)
      r_mtcmp[63:32] <= f_wmerge(r_mtcmp[63:32], w_wd, w_st);
  end

  // registered level interrupt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else r_irq <= (r_mtime >= r_mtcmp);
  end

endmodule

// File: tb/tb_sysbus_mmio.sv
// tb_sysbus_mmio: directed and random bus traffic against a
// queue/arithmetic reference of the register map.
module tb_sysbus_mmio;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       timer_irq;

  sysbus_mmio_if bus_if ();

  sysbus_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  q[$];
  bit          ovf_m;
  logic [63:0] cmp_m;
  logic [63:0] mt_base;
  logic [63:0] mt_ref;
  logic [63:0] edges = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o,
                                         input logic [31:0] n,
                                         input logic [3:0]  s);
    logic [31:0] mk;
    mk = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mk) | (n & mk);
  endfunction

  function automatic logic [63:0] mt_now();
    return mt_base + (edges - mt_ref);
  endfunction

  task automatic model_reset();
    q.delete();
    ovf_m   = 1'b0;
    cmp_m   = '1;
    mt_base = '0;
    mt_ref  = edges;
  endtask

  task automatic cyc();
    bit pop;
    pop = rst && tx_ready && (q.size() != 0);
    @(posedge clk);
    if (rst) edges++;
    if (pop) void'(q.pop_front());
    #1;
  endtask

  task automatic bus_xfer(input bit wr,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [3:0]  st,
                          output logic [31:0] rd);
    logic [31:0] off;
    logic [31:0] exp;
    logic [63:0] m;
    bit err, irq_e, will_pop, full, push_req;
    logic [7:0] hd;
    off = addr - BASE;
    err = (off >= 32) || (addr[1:0] != 2'b00) || (off >= 24);
    m = mt_now();
    irq_e = (m >= cmp_m);
    exp = '0;
    if (!err && !wr) begin
      case (off)
        4:  exp = {29'd0, ovf_m, q.size() == DEPTH, q.size() == 0};
        8:  exp = m[31:0];
        12: exp = m[63:32];
        16: exp = cmp_m[31:0];
        20: exp = cmp_m[63:32];
        default: exp = '0;
      endcase
    end
    will_pop = tx_ready && (q.size() != 0);
    full = (q.size() == DEPTH);
    push_req = wr && !err && (off == 0) && st[0];
    chk("pre_resp_valid", bus_if.bus_resp_valid, 0);
    bus_if.bus_req_valid = 1'b1;
    bus_if.bus_req_addr  = addr;
    bus_if.bus_req_write = wr;
    bus_if.bus_req_wdata = wd;
    bus_if.bus_req_wstrb = st;
    cyc();
    bus_if.bus_req_valid = 1'b0;
    if (push_req && (!full || will_pop)) q.push_back(wd[7:0]);
    if (push_req && full && !will_pop) ovf_m = 1'b1;
    if (wr && !err) begin
      case (off)
        4: if (st[0] && wd[2]) ovf_m = 1'b0;
        8: begin
          mt_base = {m[63:32], bmerge(m[31:0], wd, st)};
          mt_ref  = edges;
        end
        12: begin
          mt_base = {bmerge(m[63:32], wd, st), m[31:0]};
          mt_ref  = edges;
        end
        16: cmp_m[31:0]  = bmerge(cmp_m[31:0], wd, st);
        20: cmp_m[63:32] = bmerge(cmp_m[63:32], wd, st);
        default: ;
      endcase
    end
    hd = (q.size() != 0) ? q[0] : 8'h00;
    chk("resp_valid", bus_if.bus_resp_valid, 1);
    chk("rdata", bus_if.bus_resp_rdata, exp);
    chk("error", bus_if.bus_resp_error, err);
    chk("irq", timer_irq, irq_e);
    chk("tx_valid", tx_valid, q.size() != 0);
    chk("tx_data", tx_data, hd);
    rd = bus_if.bus_resp_rdata;
    cyc();
    chk("req_ready", bus_if.bus_req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;
    logic [31:0] addr;
    logic [63:0] m;
    bit rose;

    bus_if.bus_req_valid  = 1'b0;
    bus_if.bus_req_addr   = '0;
    bus_if.bus_req_write  = 1'b0;
    bus_if.bus_req_wdata  = '0;
    bus_if.bus_req_wstrb  = '0;
    bus_if.bus_resp_ready = 1'b1;
    tx_ready = 1'b0;
    model_reset();
    cyc();
    cyc();
    chk("rst_resp_valid", bus_if.bus_resp_valid, 0);
    chk("rst_req_ready", bus_if.bus_req_ready, 1);
    chk("rst_rdata", bus_if.bus_resp_rdata, 0);
    chk("rst_error", bus_if.bus_resp_error, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_irq", timer_irq, 0);
    rst = 1'b1;
    cyc();

    bus_xfer(1, BASE, 32'h41, 4'hF, rd);
    chk("tx41_valid", tx_valid, 1);
    chk("tx41_data", tx_data, 8'h41);
    bus_xfer(0, BASE + 4, 0, 4'hF, rd);
    chk("status_one", rd, 32'h0);
    for (int i = 0; i < 8; i++)
      bus_xfer(1, BASE, 32'h50 + i, 4'h1, rd);
    bus_xfer(0, BASE + 4, 0, 4'hF, rd);
    chk("status_ovf", rd, 32'h6);
    bus_xfer(1, BASE + 4, 32'h4, 4'hF, rd);
    bus_xfer(0, BASE + 4, 0, 4'hF, rd);
    chk("status_clr", rd, 32'h2);

    bus_xfer(0, BASE + 32'h18, 0, 4'hF, rd);
    chk("hole_rdata", rd, 0);
    chk("hole_err", bus_if.bus_resp_error, 1);
    bus_xfer(0, BASE + 32'h02, 0, 4'hF, rd);
    chk("misal_rdata", rd, 0);
    chk("misal_err", bus_if.bus_resp_error, 1);
    bus_xfer(0, BASE - 32'h4, 0, 4'hF, rd);
    chk("below_rdata", rd, 0);
    chk("below_err", bus_if.bus_resp_error, 1);

    rst = 1'b0;
    model_reset();
    cyc();
    rst = 1'b1;
    bus_xfer(1, BASE + 32'h10, 32'd20, 4'hF, rd);
    bus_xfer(1, BASE + 32'h14, 32'd0, 4'hF, rd);
    rose = 1'b0;
    for (int i = 0; i < 60 && !rose; i++) begin
      cyc();
      if (timer_irq) rose = 1'b1;
    end
    chk("irq_rose", rose, 1);
    chk("irq_rise_mtime", mt_now(), 64'd21);
    bus_xfer(1, BASE + 32'h14, 32'd1, 4'hF, rd);
    chk("irq_fell", timer_irq, 0);

    bus_if.bus_resp_ready = 1'b0;
    m = mt_now();
    exp = m[31:0];
    bus_if.bus_req_valid = 1'b1;
    bus_if.bus_req_addr  = BASE + 32'h8;
    bus_if.bus_req_write = 1'b0;
    cyc();
    bus_if.bus_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", bus_if.bus_resp_valid, 1);
      chk("hold_req_ready", bus_if.bus_req_ready, 0);
      chk("hold_rdata", bus_if.bus_resp_rdata, exp);
      chk("hold_error", bus_if.bus_resp_error, 0);
      cyc();
    end
    bus_if.bus_resp_ready = 1'b1;
    cyc();
    chk("hold_taken", bus_if.bus_resp_valid, 0);

    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    for (int i = 0; i < 200; i++) begin
      int sel;
      sel  = $urandom_range(0, 19);
      addr = BASE + 32'(4 * $urandom_range(0, 7));
      if (sel == 0) addr = addr + 32'($urandom_range(1, 3));
      if (sel == 1) addr = BASE + 32'(32 + 4 * $urandom_range(0, 15));
      if (sel == 2) addr = BASE - 32'(4 * $urandom_range(1, 16));
      tx_ready = 1'($urandom_range(0, 1));
      bus_xfer(1'($urandom_range(0, 1)), addr, $urandom,
               4'($urandom_range(0, 15)), rd);
    end

    bus_xfer(1, BASE + 32'h8, 32'hFFFF_FFF0, 4'hF, rd);
    bus_xfer(1, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, rd);
    for (int i = 0; i < 20; i++) cyc();
    bus_xfer(0, BASE + 32'hC, 0, 4'hF, rd);
    chk("wrap_hi", rd, 32'h0);
    bus_xfer(0, BASE + 32'h8, 0, 4'hF, rd);

    bus_if.bus_resp_ready = 1'b0;
    bus_if.bus_req_valid  = 1'b1;
    bus_if.bus_req_addr   = BASE + 32'h4;
    bus_if.bus_req_write  = 1'b0;
    cyc();
    bus_if.bus_req_valid = 1'b0;
    chk("mid_valid", bus_if.bus_resp_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus_if.bus_resp_valid, 0);
    chk("mid_rst_ready", bus_if.bus_req_ready, 1);
    model_reset();
    cyc();
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_valid", bus_if.bus_resp_valid, 0);
    end
    bus_if.bus_resp_ready = 1'b1;
    bus_xfer(0, BASE + 32'h4, 0, 4'hF, rd);
    chk("post_rst_status", rd, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
